// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: FSM state encoding and width.
package pll_sup_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_FILTER    = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_PLL_RESET = 3'd4
  } state_e;

endpackage : pll_sup_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Both flops reset to 0 so a freshly reset system never sees a stale "locked".
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give metastability a full cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: filters the PLL lock indication, releases downstream
// domain resets one after another, and pulls everything back into reset on
// loss of lock. Optional feature macro PLL_SUPERVISOR_RETRY_EN adds a lock
// timeout that pulses pll_resetb low and retries; without it pll_resetb is
// tied high and no timeout counter exists.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int NUM_DOMAINS  = 4,
  parameter int LOCK_FILTER  = 1024,
  parameter int STAGGER      = 16,
  parameter int TIMEOUT      = 1000000,
  parameter int PLL_RST_HOLD = 64,
  parameter int LOSS_CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pll_locked,
  output logic                   pll_resetb,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   all_ready,
  output logic                   lock_loss_pulse,
  output logic [LOSS_CNT_W-1:0]  lock_loss_count,
  output logic [STATE_W-1:0]     state
);

  // Parameter sanity checks, evaluated at elaboration only.
  if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8) begin : g_bad_domains
    $error("pll_lock_supervisor: NUM_DOMAINS must be 1..8");
  end
  if (LOCK_FILTER < 1 || STAGGER < 1 || LOSS_CNT_W < 1) begin : g_bad_counts
    $error("pll_lock_supervisor: LOCK_FILTER, STAGGER, LOSS_CNT_W must be >= 1");
  end
  if (TIMEOUT < 1 || PLL_RST_HOLD < 1) begin : g_bad_retry
    $error("pll_lock_supervisor: TIMEOUT and PLL_RST_HOLD must be >= 1");
  end

  localparam int FILT_W     = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam int REL_LAST_I = STAGGER * (NUM_DOMAINS - 1);
  localparam int REL_W      = (REL_LAST_I > 0) ? $clog2(REL_LAST_I + 1) : 1;

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(REL_LAST_I);

  logic                   lock_s;
  state_e                 state_q, state_d;
  logic [FILT_W-1:0]      filt_cnt_q, filt_cnt_d;
  logic [REL_W-1:0]       rel_cnt_q, rel_cnt_d;
  logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
  logic                   loss_pulse_q, loss_pulse_d;
  logic [LOSS_CNT_W-1:0]  loss_cnt_q, loss_cnt_d;
  logic                   timeout_hit;
  logic                   hold_done;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pll_locked),
    .q_o (lock_s)
  );

`ifdef PLL_SUPERVISOR_RETRY_EN
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int HOLD_W = (PLL_RST_HOLD > 1) ? $clog2(PLL_RST_HOLD) : 1;
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(PLL_RST_HOLD - 1);

  logic [TO_W-1:0]   timeout_q, timeout_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              pll_resetb_q;

  assign timeout_hit = (timeout_q == TO_LAST);
  assign hold_done   = (hold_q == HOLD_LAST);

  // Timeout runs across WAIT_LOCK and FILTER, restarts on every WAIT_LOCK
  // entry and saturates instead of wrapping; the hold counter times PLL_RESET.
  always_comb begin
    timeout_d = '0;
    hold_d    = '0;
    if ((state_q == ST_WAIT_LOCK || state_q == ST_FILTER) &&
        (state_d == ST_WAIT_LOCK || state_d == ST_FILTER) &&
        !(state_q == ST_FILTER && state_d == ST_WAIT_LOCK)) begin
      timeout_d = (timeout_q == '1) ? timeout_q : timeout_q + 1'b1;
    end
    if (state_q == ST_PLL_RESET && state_d == ST_PLL_RESET) begin
      hold_d = hold_q + 1'b1;
    end
  end

  // Retry counters and the registered, glitch-free PLL reset output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q    <= '0;
      hold_q       <= '0;
      pll_resetb_q <= 1'b1;
    end else begin
      timeout_q    <= timeout_d;
      hold_q       <= hold_d;
      pll_resetb_q <= (state_d != ST_PLL_RESET);
    end
  end

  assign pll_resetb = pll_resetb_q;
`else
  assign timeout_hit = 1'b0;
  assign hold_done   = 1'b1;
  assign pll_resetb  = 1'b1;
`endif

  // Next-state logic; lock loss always wins over forward progress so that a
  // drop on the final release cycle never lets the FSM reach RUN.
  always_comb begin
    state_d      = state_q;
    filt_cnt_d   = filt_cnt_q;
    rel_cnt_d    = rel_cnt_q;
    loss_pulse_d = 1'b0;
    loss_cnt_d   = loss_cnt_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (timeout_hit) begin
          state_d = ST_PLL_RESET;
        end else if (lock_s) begin
          state_d    = ST_FILTER;
          filt_cnt_d = '0;
        end
      end
      ST_FILTER: begin
        if (timeout_hit) begin
          state_d = ST_PLL_RESET;
        end else if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (filt_cnt_q == FILT_LAST) begin
          state_d   = ST_RELEASE;
          rel_cnt_d = '0;
        end else begin
          filt_cnt_d = filt_cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (rel_cnt_q == REL_LAST) begin
          state_d = ST_RUN;
        end else begin
          rel_cnt_d = rel_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d      = ST_WAIT_LOCK;
          loss_pulse_d = 1'b1;
          if (loss_cnt_q != '1) begin
            loss_cnt_d = loss_cnt_q + 1'b1;
          end
        end
      end
      ST_PLL_RESET: begin
        // Without the retry feature this state is unreachable; leave it at once.
        if (hold_done) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
      end
    endcase
  end

  // Domain i leaves reset once the release counter reaches STAGGER*i; computed
  // from next-state values so the registered output lines up with the state.
  for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
    localparam int REL_AT = STAGGER * gi;
    assign domain_rst_d[gi] =
      !((state_d == ST_RUN) ||
        ((state_d == ST_RELEASE) && (int'(rel_cnt_d) >= REL_AT)));
  end

  // State and counter registers; reset forces every domain back into reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_WAIT_LOCK;
      filt_cnt_q   <= '0;
      rel_cnt_q    <= '0;
      domain_rst_q <= '1;
      loss_pulse_q <= 1'b0;
      loss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      filt_cnt_q   <= filt_cnt_d;
      rel_cnt_q    <= rel_cnt_d;
      domain_rst_q <= domain_rst_d;
      loss_pulse_q <= loss_pulse_d;
      loss_cnt_q   <= loss_cnt_d;
    end
  end

  assign domain_rst      = domain_rst_q;
  assign all_ready       = (state_q == ST_RUN);
  assign lock_loss_pulse = loss_pulse_q;
  assign lock_loss_count = loss_cnt_q;
  assign state           = state_q;

endmodule : pll_lock_supervisor

// File: tb/tb_pll_lock_supervisor.sv
// Directed testbench for pll_lock_supervisor with small verification parameters.
// Covers lock-up sequencing, filter glitch restart, lock loss and saturation,
// PLL retry behaviour (PLL_SUPERVISOR_RETRY_EN) and asynchronous reset.
module tb_pll_lock_supervisor;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       pll_resetb;
  logic [3:0] domain_rst;
  logic       all_ready;
  logic       lock_loss_pulse;
  logic [7:0] lock_loss_count;
  logic [2:0] state;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int pulse_cycles = 0;
  int resetb_low_cycles = 0;

  pll_lock_supervisor #(
    .NUM_DOMAINS  (4),
    .LOCK_FILTER  (8),
    .STAGGER      (4),
    .TIMEOUT      (100),
    .PLL_RST_HOLD (5),
    .LOSS_CNT_W   (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pll_locked      (pll_locked),
    .pll_resetb      (pll_resetb),
    .domain_rst      (domain_rst),
    .all_ready       (all_ready),
    .lock_loss_pulse (lock_loss_pulse),
    .lock_loss_count (lock_loss_count),
    .state           (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (lock_loss_pulse === 1'b1) pulse_cycles++;
    if (pll_resetb === 1'b0) resetb_low_cycles++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %s observed=%0h expected=%0h ok", tag, obs, exp);
    end else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int lows_before;

    // Reset state
    rst = 1'b1;
    pll_locked = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_domain", domain_rst, 4'b1111);
    chk("rst_ready", all_ready, 0);
    chk("rst_resetb", pll_resetb, 1);
    chk("rst_pulse", lock_loss_pulse, 0);
    chk("rst_count", lock_loss_count, 0);
    step(2);

    // Steady lock: FILTER after 3 edges, RELEASE 8 later, stagger 0/4/8/12
    rst = 1'b0;
    pll_locked = 1'b1;
    step(2);
    chk("up_wait_e2", state, 0);
    step(1);
    chk("up_filter_e3", state, 1);
    step(7);
    chk("up_filter_e10", state, 1);
    chk("up_dom_e10", domain_rst, 4'b1111);
    step(1);
    chk("up_release_e11", state, 2);
    chk("up_dom_1110", domain_rst, 4'b1110);
    step(3);
    chk("up_dom_e14", domain_rst, 4'b1110);
    step(1);
    chk("up_dom_1100", domain_rst, 4'b1100);
    step(4);
    chk("up_dom_1000", domain_rst, 4'b1000);
    step(4);
    chk("up_dom_0000", domain_rst, 4'b0000);
    chk("up_state_e23", state, 2);
    chk("up_ready_e23", all_ready, 0);
    step(1);
    chk("up_run", state, 3);
    chk("up_ready", all_ready, 1);

    // Lock drop in RUN
    pll_locked = 1'b0;
    step(2);
    chk("drop_still_run", state, 3);
    chk("drop_dom_open", domain_rst, 4'b0000);
    step(1);
    chk("drop_state", state, 0);
    chk("drop_dom", domain_rst, 4'b1111);
    chk("drop_pulse", lock_loss_pulse, 1);
    chk("drop_count", lock_loss_count, 1);
    chk("drop_ready", all_ready, 0);
    step(1);
    chk("drop_pulse_end", lock_loss_pulse, 0);
    chk("drop_count_hold", lock_loss_count, 1);

    // Single-cycle glitch during FILTER restarts the full filter
    pll_locked = 1'b1;
    step(3);
    chk("gl_filter", state, 1);
    step(3);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    chk("gl_a", state, 1);
    step(1);
    chk("gl_b", state, 1);
    step(1);
    chk("gl_back_wait", state, 0);
    chk("gl_dom", domain_rst, 4'b1111);
    step(1);
    chk("gl_refilter", state, 1);
    step(7);
    chk("gl_filter_full", state, 1);
    chk("gl_no_release", domain_rst, 4'b1111);
    step(1);
    chk("gl_release", state, 2);
    chk("gl_dom_1110", domain_rst, 4'b1110);
    step(13);
    chk("gl_run", state, 3);

    // Repeated lock loss: count saturates at 255, one pulse cycle per loss
    for (int k = 2; k <= 300; k++) begin
      pll_locked = 1'b0;
      step(3);
      if (k == 2 || k == 255 || k == 256 || k == 300)
        chk($sformatf("sat_count_%0d", k), lock_loss_count, (k > 255) ? 255 : k);
      pll_locked = 1'b1;
      step(24);
    end
    chk("sat_run", state, 3);
    chk("sat_pulse_cycles", pulse_cycles, 300);

    // Lock lost forever: retry behaviour or constant pll_resetb
    pll_locked = 1'b0;
`ifdef PLL_SUPERVISOR_RETRY_EN
    n = 0;
    while (pll_resetb === 1'b1 && n < 300) begin step(1); n++; end
    chk("retry_fall", pll_resetb, 0);
    n = 0;
    while (pll_resetb === 1'b0 && n < 50) begin step(1); n++; end
    chk("retry_low_width", n, 5);
    n = 0;
    while (pll_resetb === 1'b1 && n < 300) begin step(1); n++; end
    chk("retry_high_gap", n, 100);
    lows_before = resetb_low_cycles;
    chk("retry_low_seen", (lows_before > 0) ? 1 : 0, 1);
`else
    lows_before = resetb_low_cycles;
    step(300);
    chk("noretry_low_cycles", resetb_low_cycles - lows_before, 0);
    chk("noretry_state", state, 0);
`endif

    // Asynchronous reset in the middle of RELEASE
    rst = 1'b1;
    step(2);
    chk("rst2_count", lock_loss_count, 0);
    rst = 1'b0;
    pll_locked = 1'b1;
    step(15);
    chk("ar_dom_1100", domain_rst, 4'b1100);
    chk("ar_state_rel", state, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_dom", domain_rst, 4'b1111);
    chk("ar_state", state, 0);
    chk("ar_ready", all_ready, 0);
    step(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_pll_lock_supervisor
